// File: rtl/qdec_pkg.sv
// rtl/qdec_pkg.sv - shared state encodings, step constants and Gray helpers for the quadrature decoder
package qdec_pkg;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } qdec_state_t;

    localparam logic signed [2:0] STEP_SLOW = 3'sd1;
    localparam logic signed [2:0] STEP_FAST = 3'sd2;

    // Four single-bit moves in one direction make one detent.
    localparam logic signed [3:0] ACC_FULL = 4'sd4;

    function automatic qdec_state_t cw_next(input qdec_state_t s);
        case (s)
            S00:     cw_next = S01;
            S01:     cw_next = S11;
            S11:     cw_next = S10;
            default: cw_next = S00;
        endcase
    endfunction

    function automatic qdec_state_t ccw_next(input qdec_state_t s);
        case (s)
            S00:     ccw_next = S10;
            S10:     ccw_next = S11;
            S11:     ccw_next = S01;
            default: ccw_next = S00;
        endcase
    endfunction

endpackage

// File: rtl/qdec_filter.sv
// rtl/qdec_filter.sv - two-flop synchroniser plus stability filter for one encoder channel
module qdec_filter #(
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed from the output for FILT_CYCLES samples in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (sync2 == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            dout <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature encoder to up/dn detent pulses with speed-dependent step size
module quad_step_decoder
    import qdec_pkg::*;
#(
    parameter int FILT_CYCLES = 4,
    parameter int FAST_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_a,
    input  logic              enc_b,
    output logic              up,
    output logic              dn,
    output logic signed [2:0] b,
    output logic              err
);

    localparam int GW = $clog2(FAST_CYCLES + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(FAST_CYCLES);

    logic              filt_a;
    logic              filt_b;
    qdec_state_t       filt_state;
    qdec_state_t       state;
    qdec_state_t       state_nxt;
    logic signed [3:0] acc;
    logic signed [3:0] acc_nxt;
    logic [GW-1:0]     gap;
    logic [GW-1:0]     gap_nxt;
    logic signed [2:0] b_nxt;
    logic              up_nxt;
    logic              dn_nxt;
    logic              err_nxt;

    qdec_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_a (
        .clk  (clk),
        .rst  (rst),
        .din  (enc_a),
        .dout (filt_a)
    );

    qdec_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_b (
        .clk  (clk),
        .rst  (rst),
        .din  (enc_b),
        .dout (filt_b)
    );

    assign filt_state = qdec_state_t'({filt_a, filt_b});

    // State, accumulator, gap counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S00;
            acc   <= '0;
            gap   <= GAP_MAX;
            b     <= STEP_SLOW;
            up    <= 1'b0;
            dn    <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            gap   <= gap_nxt;
            b     <= b_nxt;
            up    <= up_nxt;
            dn    <= dn_nxt;
            err   <= err_nxt;
        end
    end

    // Track the filtered Gray position, count moves, and emit a detent on return to 00.
    always_comb begin
        state_nxt = filt_state;
        acc_nxt   = acc;
        up_nxt    = 1'b0;
        dn_nxt    = 1'b0;
        err_nxt   = 1'b0;
        b_nxt     = b;
        gap_nxt   = (gap == GAP_MAX) ? gap : gap + 1'b1;

        if (filt_state != state) begin
            if (filt_state == cw_next(state)) begin
                acc_nxt = acc + 4'sd1;
            end else if (filt_state == ccw_next(state)) begin
                acc_nxt = acc - 4'sd1;
            end else begin
                err_nxt = 1'b1;
                acc_nxt = '0;
            end

            // Only a clean four-move run counts; half turns and reversals are dropped here.
            if (filt_state == S00) begin
                if (acc_nxt == ACC_FULL) begin
                    up_nxt = 1'b1;
                end else if (acc_nxt == -ACC_FULL) begin
                    dn_nxt = 1'b1;
                end
                acc_nxt = '0;
            end
        end

        if (up_nxt || dn_nxt) begin
            b_nxt   = (gap < GAP_MAX) ? STEP_FAST : STEP_SLOW;
            gap_nxt = '0;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - self-checking bench for quad_step_decoder
module tb_quad_step_decoder;

    localparam int FILT = 4;
    localparam int FAST = 100;
    localparam int HW   = FILT + 2;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              enc_a = 1'b0;
    logic              enc_b = 1'b0;
    logic              up;
    logic              dn;
    logic              err;
    logic signed [2:0] b;

    int n_vec = 0;
    int n_bad = 0;
    int c_up  = 0;
    int c_dn  = 0;
    int c_err = 0;
    bit chk_en = 1'b0;

    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    always #5 clk = ~clk;

    quad_step_decoder #(
        .FILT_CYCLES (FILT),
        .FAST_CYCLES (FAST)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .enc_a (enc_a),
        .enc_b (enc_b),
        .up    (up),
        .dn    (dn),
        .b     (b),
        .err   (err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: raw sample history, positions as integers 0..3 around the Gray circle.
    bit ha[$];
    bit hb[$];
    bit fa, fb;
    int mpos, macc, mgap, mb;
    bit mup, mdn, merr;

    function automatic int pos_of(input bit a, input bit bb);
        case ({a, bb})
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) begin
        int np;
        int d;
        bit win_a;
        bit win_b;
        if (rst) begin
            ha.delete();
            hb.delete();
            for (int i = 0; i < HW; i++) begin
                ha.push_back(1'b0);
                hb.push_back(1'b0);
            end
            fa = 1'b0; fb = 1'b0;
            mpos = 0; macc = 0; mgap = FAST; mb = 1;
            mup = 1'b0; mdn = 1'b0; merr = 1'b0;
        end else begin
            ha.push_back(enc_a);
            hb.push_back(enc_b);
            void'(ha.pop_front());
            void'(hb.pop_front());
            np   = pos_of(fa, fb);
            d    = (np - mpos + 4) % 4;
            mup  = 1'b0;
            mdn  = 1'b0;
            merr = 1'b0;
            if (d == 2) begin
                merr = 1'b1;
                macc = 0;
            end else if (d == 1) begin
                macc += 1;
            end else if (d == 3) begin
                macc -= 1;
            end
            if (d != 0 && np == 0) begin
                if (macc == 4)  mup = 1'b1;
                if (macc == -4) mdn = 1'b1;
                macc = 0;
            end
            mpos = np;
            if (mup || mdn) begin
                mb   = (mgap < FAST) ? 2 : 1;
                mgap = 0;
            end else if (mgap < FAST) begin
                mgap += 1;
            end
            // A filtered level flips once the synchronised input has disagreed for FILT samples.
            win_a = 1'b1;
            win_b = 1'b1;
            for (int i = 0; i < FILT; i++) begin
                if (ha[i] == fa) win_a = 1'b0;
                if (hb[i] == fb) win_b = 1'b0;
            end
            if (win_a) fa = ~fa;
            if (win_b) fb = ~fb;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_outputs", int'({up, dn, err, b}), int'({mup, mdn, merr, 3'(mb)}));
            check("up_dn_exclusive", int'(up & dn), 0);
            if (up === 1'b1)  c_up++;
            if (dn === 1'b1)  c_dn++;
            if (err === 1'b1) c_err++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic [1:0] ab, input int n);
        enc_a = ab[1];
        enc_b = ab[0];
        tick(n);
    endtask

    typedef struct {
        logic [1:0] ab;
        int         hold;
        int         e_up;
        int         e_dn;
        int         e_err;
        int         e_b;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] ab, input int hold, input int u, input int d, input int e, input int bb);
        vec_t v;
        v.ab = ab; v.hold = hold; v.e_up = u; v.e_dn = d; v.e_err = e; v.e_b = bb;
        tbl.push_back(v);
    endtask

    initial begin
        int s_up, s_dn, s_err;
        int lat;
        int p;
        int dir;
        int nsteps;
        int hold;

        rst = 1'b1;
        tick(3);
        chk_en = 1'b1;
        check("reset_up",  int'(up),  0);
        check("reset_dn",  int'(dn),  0);
        check("reset_err", int'(err), 0);
        check("reset_b",   int'(b),   1);
        rst = 1'b0;
        drive(2'b00, 120);

        // rest, CW detent (slow), CCW twice (fast then slow), error, partial, CW, half turn, CW slow, CW fast
        add(2'b00, 20, 0, 0, 0, 1);
        add(2'b01, 20, 0, 0, 0, 1);
        add(2'b11, 20, 0, 0, 0, 1);
        add(2'b10, 20, 0, 0, 0, 1);
        add(2'b00, 20, 1, 0, 0, 1);
        add(2'b10, 20, 0, 0, 0, 1);
        add(2'b11, 20, 0, 0, 0, 1);
        add(2'b01, 20, 0, 0, 0, 1);
        add(2'b00, 20, 0, 1, 0, 2);
        add(2'b10, 30, 0, 0, 0, 2);
        add(2'b11, 30, 0, 0, 0, 2);
        add(2'b01, 30, 0, 0, 0, 2);
        add(2'b00, 30, 0, 1, 0, 1);
        add(2'b11, 20, 0, 0, 1, 1);
        add(2'b10, 20, 0, 0, 0, 1);
        add(2'b00, 20, 0, 0, 0, 1);
        add(2'b01, 20, 0, 0, 0, 1);
        add(2'b11, 20, 0, 0, 0, 1);
        add(2'b10, 20, 0, 0, 0, 1);
        add(2'b00, 20, 1, 0, 0, 1);
        add(2'b01, 20, 0, 0, 0, 1);
        add(2'b11, 20, 0, 0, 0, 1);
        add(2'b01, 20, 0, 0, 0, 1);
        add(2'b00, 20, 0, 0, 0, 1);
        add(2'b01, 20, 0, 0, 0, 1);
        add(2'b11, 20, 0, 0, 0, 1);
        add(2'b10, 20, 0, 0, 0, 1);
        add(2'b00, 20, 1, 0, 0, 1);
        add(2'b01, 20, 0, 0, 0, 1);
        add(2'b11, 20, 0, 0, 0, 1);
        add(2'b10, 20, 0, 0, 0, 1);
        add(2'b00, 20, 1, 0, 0, 2);

        foreach (tbl[i]) begin
            s_up = c_up; s_dn = c_dn; s_err = c_err;
            drive(tbl[i].ab, tbl[i].hold);
            check($sformatf("tbl%0d_up", i),  c_up - s_up,   tbl[i].e_up);
            check($sformatf("tbl%0d_dn", i),  c_dn - s_dn,   tbl[i].e_dn);
            check($sformatf("tbl%0d_err", i), c_err - s_err, tbl[i].e_err);
            check($sformatf("tbl%0d_b", i),   int'(b),       tbl[i].e_b);
        end

        // Latency from the edge that completes a detent to the up pulse.
        drive(2'b00, 120);
        drive(2'b01, 20);
        drive(2'b11, 20);
        drive(2'b10, 20);
        s_dn = c_dn;
        enc_a = 1'b0;
        enc_b = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (up === 1'b1 && lat < 0) lat = k;
        end
        check("latency", lat, FILT + 3);
        check("latency_b", int'(b), 1);
        check("latency_dn", c_dn - s_dn, 0);

        // A 3-cycle glitch on A is dropped: B moving next is a legal single-bit step.
        drive(2'b00, 20);
        s_up = c_up; s_dn = c_dn; s_err = c_err;
        drive(2'b10, 3);
        drive(2'b01, 20);
        drive(2'b00, 20);
        check("glitch3_err", c_err - s_err, 0);
        check("glitch3_pulses", (c_up - s_up) + (c_dn - s_dn), 0);
        // A 4-cycle-stable A is accepted, so moving to 01 is a double change.
        s_err = c_err;
        drive(2'b10, 4);
        drive(2'b01, 20);
        drive(2'b00, 20);
        check("stable4_err", c_err - s_err, 1);

        // Reset in the middle of a CW turn, then finish it: no detent.
        drive(2'b01, 20);
        drive(2'b11, 20);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        s_up = c_up; s_dn = c_dn;
        drive(2'b11, 20);
        drive(2'b10, 20);
        drive(2'b00, 20);
        check("rst_mid_pulses", (c_up - s_up) + (c_dn - s_dn), 0);
        s_up = c_up;
        drive(2'b01, 20);
        drive(2'b11, 20);
        drive(2'b10, 20);
        drive(2'b00, 20);
        check("rst_after_up", c_up - s_up, 1);
        check("rst_after_b", int'(b), 1);

        // Random bursts of steps, glitches, double changes and resets against the model.
        p = 0;
        for (int i = 0; i < 500; i++) begin
            dir = ($urandom_range(0, 1) == 0) ? 1 : 3;
            nsteps = $urandom_range(1, 8);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) begin
                p = (p + 2) % 4;
                drive(gray[p], $urandom_range(4, 20));
            end
            for (int s = 0; s < nsteps; s++) begin
                p = (p + dir) % 4;
                hold = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 20);
                drive(gray[p], hold);
            end
        end
        drive(2'b00, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
